equality_compare_arbiter: RTL and testbench

Shares one 1-bit equality cell (the existing `bitEquality` XNOR cell) between two requesters. The comparison runs serially, one bit position per cycle, LSB first. Each request latches a pair of WIDTH-bit operands and gets a single-cycle `done` pulse with the `eq` result, and the scan stops early at the first mismatching bit. The block replaces replicated parallel comparators where area matters more than latency, and sits between requesting control units and the comparison datapath.

---
 rtl/equality_compare_arbiter_pkg.sv | 25 ++
 rtl/bitEquality.sv | 11 +
 rtl/equality_compare_arbiter.sv | 123 ++++++++++++
 tb/tb_equality_compare_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/equality_compare_arbiter_pkg.sv
// Shared types and helpers for the serial equality-compare arbiter.
// Holds the FSM state encoding, the default operand width and the arbitration rule.
package equality_compare_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Round-robin pick: returns 1 when requester 1 wins, 0 when requester 0 wins.
  function automatic logic rr_winner(input logic [1:0] req, input logic last);
    if (req == 2'b11) begin
      return ~last;
    end
    return req[1];
  endfunction

  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/bitEquality.sv
// Existing 1-bit equality cell: XNOR of its two inputs.
// Shared between both requesters by the arbiter.
module bitEquality (
  input  logic i_a,
  input  logic i_b,
  output logic o_eq
);

  assign o_eq = ~(i_a ^ i_b);

endmodule

// File: rtl/equality_compare_arbiter.sv
// Two-requester arbiter around one shared bit-serial equality cell.
// Operands are scanned LSB first; the scan stops at the first mismatching bit.
module equality_compare_arbiter
  import equality_compare_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             eq
);

  localparam int              IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [IDX_W-1:0] r_idx;
  logic [1:0]       r_gnt;
  logic             r_eq;
  logic             r_last;
  logic             w_bit_eq;
  logic             w_winner;
  logic             w_last_bit;

  bitEquality u_bit_eq (
    .i_a  (r_sa[0]),
    .i_b  (r_sb[0]),
    .o_eq (w_bit_eq)
  );

  assign w_winner   = rr_winner(req, r_last);
  assign w_last_bit = (r_idx == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves w_state_next unassigned,
    // which would otherwise infer a latch.
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (|req) w_state_next = SCAN;
      SCAN:    if (!w_bit_eq || w_last_bit) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Control registers: owner, result, round-robin history and bit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt  <= 2'b00;
      r_eq   <= 1'b0;
      r_last <= 1'b1;
      r_idx  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_gnt <= owner_onehot(w_winner);
            r_idx <= '0;
          end
        end
        SCAN: begin
          if (!w_bit_eq) begin
            r_eq <= 1'b0;
          end else if (w_last_bit) begin
            r_eq <= 1'b1;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          r_last <= r_gnt[1];
          r_gnt  <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  // NOTE: operand shift registers carry no reset; they are always loaded at
  // grant before the cell reads them, so a reset would only cost area.
  always_ff @(posedge clk) begin
    case (r_state)
      IDLE: begin
        if (|req) begin
          r_sa <= w_winner ? a1 : a0;
          r_sb <= w_winner ? b1 : b0;
        end
      end
      SCAN: begin
        r_sa <= r_sa >> 1;
        r_sb <= r_sb >> 1;
      end
      default: ;
    endcase
  end

  assign gnt  = r_gnt;
  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign eq   = r_eq;

endmodule

// File: tb/tb_equality_compare_arbiter.sv
// Self-checking bench: transaction-level model of the arbiter compared every cycle,
// directed scenarios with literal latencies, then randomized traffic with resets.
module tb_equality_compare_arbiter;

  localparam int W = 5;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   req   = 2'b00;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0]   gnt;
  logic         busy, done, eq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  equality_compare_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .a0    (a0),
    .b0    (b0),
    .a1    (a1),
    .b1    (b1),
    .gnt   (gnt),
    .busy  (busy),
    .done  (done),
    .eq    (eq)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Number of cycles the shared cell is busy scanning for one operand pair.
  function automatic int scan_len(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < W; i++) begin
      if (a[i] != b[i]) return i + 1;
    end
    return W;
  endfunction

  // Transaction-level model: cycles left in the current operation, owner, history.
  int           m_left  = 0;
  logic         m_last  = 1'b1;
  logic         m_eq    = 1'b0;
  logic         m_pend  = 1'b0;
  logic         m_owner = 1'b0;
  logic         m_valid = 1'b0;
  logic [W-1:0] ma, mb;

  always @(posedge clk) begin
    if (reset) begin
      m_left  = 0;
      m_last  = 1'b1;
      m_eq    = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_left > 0) begin
        if (m_left == 1) m_last = m_owner;
        m_left = m_left - 1;
        if (m_left == 1) m_eq = m_pend;
      end else if (req != 2'b00) begin
        m_owner = (req == 2'b11) ? ~m_last : req[1];
        ma      = m_owner ? a1 : a0;
        mb      = m_owner ? b1 : b0;
        m_pend  = (ma == mb);
        m_left  = scan_len(ma, mb) + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("gnt",  int'(gnt),  (m_left > 0) ? (m_owner ? 2 : 1) : 0);
      check("busy", int'(busy), int'(m_left > 0));
      check("done", int'(done), int'(m_left == 1));
      check("eq",   int'(eq),   int'(m_eq));
    end
  end

  task automatic at_pos();
    @(posedge clk);
    #1;
  endtask

  // Latency is counted in cycles from the cycle in which this task is called.
  task automatic wait_done(input string name, input int exp_lat, input logic exp_eq,
                           input logic [1:0] exp_gnt);
    int lat = -1;
    @(negedge clk);
    for (int i = 1; i <= 3 * W + 10; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_eq"},  int'(eq),  int'(exp_eq));
    check({name, "_gnt"}, int'(gnt), int'(exp_gnt));
  endtask

  function automatic logic [W-1:0] pick_b(input logic [W-1:0] a);
    case ($urandom_range(0, 2))
      0:       return a;
      1:       return a ^ (W'(1) << $urandom_range(0, W - 1));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic saw_done;

    check("model_full_match", scan_len(5'b10101, 5'b10101), 5);
    check("model_bit1_miss",  scan_len(5'b00101, 5'b00011), 2);
    check("model_bit0_miss",  scan_len(5'b10101, 5'b01010), 1);

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single requester 0, full match.
    a0 = 5'b00001; b0 = 5'b00001; req = 2'b01;
    wait_done("t1", 6, 1'b1, 2'b01);
    at_pos(); req = 2'b00;
    at_pos();

    // Single requester 1, mismatch at bit 1.
    a1 = 5'b00101; b1 = 5'b00011; req = 2'b10;
    wait_done("t2", 3, 1'b0, 2'b10);
    at_pos(); req = 2'b00;
    at_pos();

    // Contention straight out of reset: requester 0 wins first.
    reset = 1'b1;
    at_pos(); reset = 1'b0;
    a0 = 5'b11111; b0 = 5'b11111; a1 = 5'b10101; b1 = 5'b01010; req = 2'b11;
    wait_done("t3a", 6, 1'b1, 2'b01);
    at_pos(); req = 2'b10;
    wait_done("t3b", 2, 1'b0, 2'b10);
    at_pos(); req = 2'b00;
    at_pos();

    // Operand change after grant is ignored.
    a0 = 5'b10101; b0 = 5'b10101; req = 2'b01;
    at_pos(); req = 2'b00;
    at_pos(); a0 = 5'b00000;
    wait_done("t4", 4, 1'b1, 2'b01);
    at_pos();
    at_pos();

    // Reset in the middle of a scan aborts silently.
    a0 = 5'b11111; b0 = 5'b11111; req = 2'b01;
    at_pos(); req = 2'b00;
    at_pos();
    at_pos(); reset = 1'b1;
    at_pos(); reset = 1'b0;
    check("t5_busy", int'(busy), 0);
    check("t5_gnt",  int'(gnt),  0);
    check("t5_eq",   int'(eq),   0);
    saw_done = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("t5_no_done", int'(saw_done), 0);

    // Held req1 is re-granted; round-robin alternates under contention.
    at_pos(); a1 = 5'b00011; b1 = 5'b00011; req = 2'b10;
    wait_done("t6a", 6, 1'b1, 2'b10);
    at_pos();
    at_pos();
    check("t6_regrant", int'(gnt), 2);
    req = 2'b11;
    wait_done("t6b", 5, 1'b1, 2'b10);
    at_pos();
    at_pos();
    check("t6_rr_to_0", int'(gnt), 1);
    wait_done("t6c", 5, 1'b1, 2'b01);
    at_pos();
    at_pos();
    check("t6_rr_to_1", int'(gnt), 2);
    req = 2'b00;
    repeat (2 * W) at_pos();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 800; c++) begin
      at_pos();
      reset = ($urandom_range(0, 149) == 0);
      req   = 2'($urandom_range(0, 3));
      a0    = W'($urandom);
      b0    = pick_b(a0);
      a1    = W'($urandom);
      b1    = pick_b(a1);
    end
    reset = 1'b0;
    req   = 2'b00;
    repeat (3 * W + 5) at_pos();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
